// File: rtl/kbd_mouse_pkg.sv
// Shared encodings for the keyboard/mouse dispatch block.
// Event types, mouse packet states and accumulator axis select.
package kbd_mouse_pkg;

  typedef enum logic [1:0] {
    KMS_MOUSE_X = 2'd0,
    KMS_MOUSE_Y = 2'd1,
    KMS_KEY     = 2'd2,
    KMS_OSD     = 2'd3
  } kms_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_X = 2'd1,
    GOT_Y = 2'd2
  } mouse_state_t;

  typedef enum logic [1:0] {
    AX_NONE = 2'd0,
    AX_X    = 2'd1,
    AX_Y    = 2'd2,
    AX_W    = 2'd3
  } axis_t;

endpackage

// File: rtl/kms_fifo.sv
// First-word fall-through FIFO for the keycode channel.
// A push at full is accepted only when a pop frees a slot that cycle.
module kms_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/kbd_mouse_dispatch.sv
// Distributes user-IO keyboard/mouse events to mouse accumulators,
// a buffered keycode channel and the OSD key register.
module kbd_mouse_dispatch
  import kbd_mouse_pkg::*;
#(
  parameter int          KBD_DEPTH   = 8,
  parameter int          ACC_W       = 10,
  parameter logic [23:0] KBD_TIMEOUT = 24'd2_000_000
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             kms_strobe,
  input  logic [1:0]       kms_type,
  input  logic [7:0]       kms_data,
  input  logic             mouse_idx,
  input  logic             mouse_rd,
  input  logic             mouse_sel,
  output logic [ACC_W-1:0] mouse_x,
  output logic [ACC_W-1:0] mouse_y,
  output logic [ACC_W-1:0] mouse_wheel,
  output logic             mouse_rd_valid,
  output logic             kbd_valid,
  output logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  output logic             kbd_overflow,
  output logic             kbd_timeout,
  input  logic             kbd_ovf_clr,
  output logic             osd_valid,
  output logic [7:0]       osd_data,
  input  logic             osd_ack
);

  mouse_state_t     state, state_n;
  axis_t            axis;
  kms_type_t        etype;
  logic [ACC_W-1:0] acc_x [2];
  logic [ACC_W-1:0] acc_y [2];
  logic [ACC_W-1:0] acc_w [2];
  logic [1:0]       clr;
  logic [1:0]       hit;

  assign etype = kms_type_t'(kms_type);
  assign clr   = mouse_rd ? (mouse_sel ? 2'b10 : 2'b01) : 2'b00;
  assign hit   = mouse_idx ? 2'b10 : 2'b01;

  function automatic logic [ACC_W-1:0] sat_add(
    input logic [ACC_W-1:0] a,
    input logic [7:0]       d
  );
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-7){d[7]}}, d};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                      : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  // A read clears first, so a same-cycle delta lands on zero.
  function automatic logic [ACC_W-1:0] acc_next(
    input logic [ACC_W-1:0] a,
    input logic             c,
    input logic             add,
    input logic [7:0]       d
  );
    logic [ACC_W-1:0] base;
    base = c ? '0 : a;
    return add ? sat_add(base, d) : base;
  endfunction

  always_comb begin
    state_n = state;
    axis    = AX_NONE;
    if (kms_strobe) begin
      unique case (etype)
        KMS_MOUSE_X: begin
          axis    = AX_X;
          state_n = GOT_X;
        end
        KMS_MOUSE_Y: begin
          axis    = (state == GOT_Y) ? AX_W : AX_Y;
          state_n = GOT_Y;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      mouse_x        <= '0;
      mouse_y        <= '0;
      mouse_wheel    <= '0;
      mouse_rd_valid <= 1'b0;
      for (int m = 0; m < 2; m++) begin
        acc_x[m] <= '0;
        acc_y[m] <= '0;
        acc_w[m] <= '0;
      end
    end else begin
      state          <= state_n;
      mouse_rd_valid <= mouse_rd;
      if (mouse_rd) begin
        mouse_x     <= acc_x[mouse_sel];
        mouse_y     <= acc_y[mouse_sel];
        mouse_wheel <= acc_w[mouse_sel];
      end
      for (int m = 0; m < 2; m++) begin
        acc_x[m] <= acc_next(acc_x[m], clr[m],
                             hit[m] && axis == AX_X, kms_data);
        acc_y[m] <= acc_next(acc_y[m], clr[m],
                             hit[m] && axis == AX_Y, kms_data);
        acc_w[m] <= acc_next(acc_w[m], clr[m],
                             hit[m] && axis == AX_W, kms_data);
      end
    end
  end

  logic        key_push;
  logic        key_pop;
  logic        key_empty;
  logic        key_full;
  logic        key_drop;
  logic        stalled;
  logic [23:0] stall;

  assign key_push    = kms_strobe && etype == KMS_KEY;
  assign kbd_valid   = ~key_empty;
  assign stalled     = kbd_valid & ~kbd_ready;
  assign kbd_timeout = stalled && stall == KBD_TIMEOUT - 24'd1;
  assign key_pop     = (kbd_valid & kbd_ready) | kbd_timeout;

  kms_fifo #(
    .DEPTH (KBD_DEPTH),
    .W     (8)
  ) u_key_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .push  (key_push),
    .din   (kms_data),
    .pop   (key_pop),
    .dout  (kbd_data),
    .empty (key_empty),
    .full  (key_full),
    .drop  (key_drop)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stall        <= '0;
      kbd_overflow <= 1'b0;
      osd_valid    <= 1'b0;
      osd_data     <= '0;
    end else begin
      stall <= (!stalled || kbd_timeout) ? '0 : stall + 24'd1;
      if (key_drop)         kbd_overflow <= 1'b1;
      else if (kbd_ovf_clr) kbd_overflow <= 1'b0;
      if (kms_strobe && etype == KMS_OSD) begin
        osd_valid <= 1'b1;
        osd_data  <= kms_data;
      end else if (osd_ack) begin
        osd_valid <= 1'b0;
      end
    end
  end

endmodule
